// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the execute-stage control and muldiv_unit.
// Master drives start/flush/op/operands. Slave returns result/busy/done.
// All signals are sampled or produced on the unit's clock edge.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] result;
  logic             busy;
  logic             done;

  modport master (output start, flush, funct3, src_a, src_b,
                  input  result, busy, done);
  modport slave  (input  start, flush, funct3, src_a, src_b,
                  output result, busy, done);
endinterface

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide, fast paths.
// Latency: done is WIDTH+1 cycles after accepted start; fast paths (x/0, MIN/-1) take 1 cycle.
// Backpressure: no queueing; start is only seen in IDLE and the caller stalls while busy is high.
module muldiv_unit #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [WIDTH-1:0]   a_q;       // multiplicand magnitude
  logic [WIDTH-1:0]   b_q;       // divisor magnitude
  logic [WIDTH-1:0]   hi_q;      // product high half / partial remainder
  logic [WIDTH-1:0]   lo_q;      // multiplier being shifted out / dividend shifting into quotient
  logic               neg_q;     // final result must be negated
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   result_q;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   fin;

  logic               a_sgn;
  logic               b_sgn;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               neg_cap;
  logic               fast_hit;
  logic [WIDTH-1:0]   fast_val;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  // Capture-side decode: signed operands become magnitudes, sign of result remembered, fast paths detected.
  always_comb begin
    a_sgn    = bus.src_a[WIDTH-1] &&
               (bus.funct3 == 3'b001 || bus.funct3 == 3'b010 || bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
    b_sgn    = bus.src_b[WIDTH-1] &&
               (bus.funct3 == 3'b001 || bus.funct3 == 3'b100 || bus.funct3 == 3'b110);
    a_mag    = a_sgn ? (~bus.src_a + 1'b1) : bus.src_a;
    b_mag    = b_sgn ? (~bus.src_b + 1'b1) : bus.src_b;
    // remainder follows the dividend only; everything else follows the product/quotient sign
    neg_cap  = (bus.funct3 == 3'b110) ? a_sgn : (a_sgn ^ b_sgn);
    fast_hit = 1'b0;
    fast_val = '0;
    if (bus.funct3[2]) begin
      if (bus.src_b == '0) begin
        fast_hit = 1'b1;
        fast_val = bus.funct3[1] ? bus.src_a : '1;
      end else if (!bus.funct3[0] && bus.src_a == MIN_NEG && bus.src_b == '1) begin
        fast_hit = 1'b1;
        fast_val = bus.funct3[1] ? '0 : bus.src_a;
      end
    end
  end

  // One datapath iteration plus the sign-corrected final value for the last iteration.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    if (!op_q[2]) begin
      hi_d = mul_sum[WIDTH:1];
      lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
    end else if (div_shift >= {1'b0, b_q}) begin
      hi_d = WIDTH'(div_shift - {1'b0, b_q});
      lo_d = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      hi_d = div_shift[WIDTH-1:0];
      lo_d = {lo_q[WIDTH-2:0], 1'b0};
    end
    prod = neg_q ? (~{hi_d, lo_d} + 1'b1) : {hi_d, lo_d};
    quo  = neg_q ? (~lo_d + 1'b1) : lo_d;
    rem  = neg_q ? (~hi_d + 1'b1) : hi_d;
    case (op_q)
      3'b000:                 fin = prod[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fin = prod[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fin = quo;
      default:                fin = rem;
    endcase
  end

  // Control FSM with registered result/busy/done; flush aborts without touching result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else if (bus.flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            op_q   <= bus.funct3;
            a_q    <= a_mag;
            b_q    <= b_mag;
            hi_q   <= '0;
            lo_q   <= bus.funct3[2] ? a_mag : b_mag;
            neg_q  <= neg_cap;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if (fast_hit) begin
              result_q <= fast_val;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= fin;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result = result_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, random ops vs an arithmetic model,
// flush/reset aborts, start ignored while busy, back-to-back acceptance.
module tb_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) ifc ();
  muldiv_unit #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Architectural RV32M result computed with plain wide arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax_s, bx_s, ax_u, bx_u, p;
    int sa, sb;
    ax_s = {{32{a[31]}}, a};
    bx_s = {{32{b[31]}}, b};
    ax_u = {32'b0, a};
    bx_u = {32'b0, b};
    sa = a;
    sb = b;
    case (f3)
      3'd0: begin p = ax_u * bx_u; return p[31:0]; end
      3'd1: begin p = ax_s * bx_s; return p[63:32]; end
      3'd2: begin p = ax_s * bx_u; return p[63:32]; end
      3'd3: begin p = ax_u * bx_u; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(sa / sb);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'(sa % sb);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (f3[2] && b == 32'd0) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Issue one op, scramble operands after acceptance, wait (bounded) for done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_ok);
    @(negedge clk);
    ifc.start = 1'b1; ifc.funct3 = f3; ifc.src_a = a; ifc.src_b = b;
    lat = 0; busy_ok = 1'b1; res = 'x;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == 1) begin
        ifc.start = 1'b0; ifc.src_a = $urandom; ifc.src_b = $urandom; ifc.funct3 = 3'($urandom);
      end
      if (ifc.busy !== 1'b1) busy_ok = 1'b0;
      if (ifc.done === 1'b1) begin
        lat = c;
        res = ifc.result;
        break;
      end
    end
  endtask

  task automatic do_vec(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    logic [31:0] res;
    int lat;
    logic bok;
    run_op(f3, a, b, res, lat, bok);
    chk(tag, res, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_busy"}, {31'b0, bok}, 32'd1);
  endtask

  initial begin
    logic [31:0] res, ra, rb;
    logic [2:0]  rf;
    int lat, ndone;
    logic bok;

    ifc.start = 1'b0; ifc.flush = 1'b0; ifc.funct3 = 3'd0; ifc.src_a = '0; ifc.src_b = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_result", ifc.result, 32'd0);
    chk("rst_busy", {31'b0, ifc.busy}, 32'd0);
    chk("rst_done", {31'b0, ifc.done}, 32'd0);
    rst_n = 1'b1;

    // Directed cases
    do_vec("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    @(negedge clk);
    chk("idle_after_done_busy", {31'b0, ifc.busy}, 32'd0);
    chk("idle_after_done_done", {31'b0, ifc.done}, 32'd0);
    do_vec("mulh_min_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
    do_vec("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_vec("mulhsu_m1", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    do_vec("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_vec("rem_m7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_vec("divu_100_7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    do_vec("remu_100_7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    do_vec("div_by_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    do_vec("rem_by_0", 3'd6, 32'd5, 32'd0, 32'd5, 1);
    do_vec("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_vec("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    repeat (3) @(negedge clk);
    chk("result_hold", ifc.result, 32'd0);

    // Random ops against the model, back to back
    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run_op(rf, ra, rb, res, lat, bok);
      chk($sformatf("rand%0d_f%0d", i, rf), res, model(rf, ra, rb));
      chk($sformatf("rand%0d_lat", i), 32'(lat), 32'(model_lat(rf, ra, rb)));
    end

    // start re-pulsed during CALC is ignored
    @(negedge clk);
    ifc.start = 1'b1; ifc.funct3 = 3'd0; ifc.src_a = 32'd123; ifc.src_b = 32'd456;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) ifc.start = 1'b0;
      if (c == 5) begin ifc.start = 1'b1; ifc.funct3 = 3'd4; ifc.src_a = 32'd1; ifc.src_b = 32'd1; end
      if (c == 6) ifc.start = 1'b0;
      if (ifc.done === 1'b1 && lat == 0) begin
        lat = c;
        chk("repulse_result", ifc.result, 32'd56088);
      end
      if (lat != 0 && c == lat + 1) begin
        chk("repulse_no_queue", {31'b0, ifc.busy}, 32'd0);
        break;
      end
    end
    chk("repulse_lat", 32'(lat), 32'd33);

    // flush at cycle 10 of a mul: idle at 11, no done, result unchanged
    @(negedge clk);
    ifc.start = 1'b1; ifc.funct3 = 3'd0; ifc.src_a = 32'd5; ifc.src_b = 32'd9;
    ndone = 0;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) ndone++;
      if (c == 1) ifc.start = 1'b0;
      if (c == 10) ifc.flush = 1'b1;
      if (c == 11) begin
        ifc.flush = 1'b0;
        chk("flush_idle", {31'b0, ifc.busy}, 32'd0);
      end
    end
    chk("flush_no_done", 32'(ndone), 32'd0);
    chk("flush_result_kept", ifc.result, 32'd56088);

    // synchronous reset at cycle 5 of a divu
    @(negedge clk);
    ifc.start = 1'b1; ifc.funct3 = 3'd5; ifc.src_a = 32'd1000; ifc.src_b = 32'd3;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (c == 1) ifc.start = 1'b0;
      if (c == 5) rst_n = 1'b0;
      if (c == 6) begin
        chk("midrst_result", ifc.result, 32'd0);
        chk("midrst_busy", {31'b0, ifc.busy}, 32'd0);
        chk("midrst_done", {31'b0, ifc.done}, 32'd0);
        rst_n = 1'b1;
      end
    end
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (ifc.done === 1'b1) ndone++;
    end
    chk("midrst_no_done", 32'(ndone), 32'd0);
    do_vec("post_rst_divu", 3'd5, 32'd100, 32'd7, 32'd14, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
